operand_shifter: RTL
====================

OPERAND_SHIFTER -- requirements
Module: operand_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (minimum 8).
REQ-002 SHALL have parameter AMT_W, default 4, shift-amount field width.
REQ-003 SHALL have parameters IMM0_W, IMM1_W, IMM2_W, defaults 4, 5, 6, immediate field widths selected by opsel 1/2/3 (each < WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-007 SHALL have port opsel  input  2  operand source: 0 rb, 1 sext ir[IMM0_W-1:0], 2 sext ir[IMM1_W-1:0], 3 sext ir[IMM2_W-1:0].
REQ-008 SHALL have port rb  input  WIDTH  register operand.
REQ-009 SHALL have port ir  input  WIDTH  instruction word.
REQ-010 SHALL have port shmode  input  2  0 pass, 1 LSHF, 2 RSHFL, 3 RSHFA.
REQ-011 SHALL have port amount  input  AMT_W  shift distance in bits.
REQ-012 SHALL have port busy  output  1  high while shifting.
REQ-013 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-014 SHALL have port result  output  WIDTH  shifted operand, held until next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 On start with busy=0 (state IDLE or DONE), SHALL capture selected sign-extended operand, shmode and amount into internal registers.
REQ-017 If captured shmode=0 or amount=0, SHALL go directly to DONE; result = unshifted operand; done at T+1 (T = accept edge).
REQ-018 Otherwise SHALL enter SHIFT with counter=amount and shift one bit per cycle, decrementing counter; after amount SHIFT cycles go to DONE; done at T+1+amount.
REQ-019 LSHF SHALL shift left, filling 0; RSHFL SHALL shift right, filling 0; RSHFA SHALL shift right, replicating bit WIDTH-1.
REQ-020 amount >= WIDTH SHALL be honoured literally (result all-zero, or all sign bits for RSHFA); no saturation or modulo.
REQ-021 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-022 start while busy=1 SHALL be ignored; operand, mode and counter unchanged.
REQ-023 start asserted in DONE SHALL be accepted (back-to-back); done still pulses that cycle for the previous job.
REQ-024 DONE without start SHALL return to IDLE next cycle; result retained.
REQ-025 Input ports SHALL be sampled only at the accept edge; changes during SHIFT SHALL have no effect.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, result 0, busy 0, done 0, counter 0.
REQ-027 Reset during SHIFT SHALL abort the job with no done pulse; first accepted start after reset deassertion SHALL behave per REQ-016.

Structure
REQ-028 SHALL place shmode encodings, opsel encodings and FSM state enum in shared package lc3b_pkg.
REQ-029 SHALL implement operand selection/sign extension as combinational sub-module operand_select (parameters WIDTH, IMM0_W..IMM2_W).
REQ-030 SHALL keep one working shift register doubling as result; no barrel shifter.

Verification (WIDTH=16, AMT_W=4)
REQ-031 opsel=0, rb=0x8001, LSHF, amount=3 -> busy T+1..T+3, done at T+4, result=0x0008.
REQ-032 opsel=1, ir[3:0]=0xA, RSHFA, amount=1 -> done at T+2, result=0xFFFD.
REQ-033 opsel=0, rb=0x8000, RSHFL, amount=15 -> done at T+16, result=0x0001; RSHFA same input -> 0xFFFF.
REQ-034 opsel=3, ir[5:0]=0x20, LSHF, amount=0 -> done at T+1, busy never high, result=0xFFE0.
REQ-035 start pulses with changed rb during SHIFT -> ignored, original result delivered; reset mid-SHIFT -> busy 0, result 0, no done pulse.
REQ-036 start in DONE cycle (opsel=2, ir[4:0]=0x10, pass) -> done at next cycle, result=0xFFF0, previous result visible during first done.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared encodings for the operand shifter: shift modes, operand sources and
// the shifter control states.
package lc3b_pkg;

    typedef enum logic [1:0] {
        SH_PASS  = 2'd0,
        SH_LSHF  = 2'd1,
        SH_RSHFL = 2'd2,
        SH_RSHFA = 2'd3
    } shmode_t;

    typedef enum logic [1:0] {
        OP_RB   = 2'd0,
        OP_IMM0 = 2'd1,
        OP_IMM1 = 2'd2,
        OP_IMM2 = 2'd3
    } opsel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/operand_select.sv
// Combinational operand mux: register operand or one of three sign-extended
// immediate fields taken from the low bits of the instruction word.
module operand_select
    import lc3b_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int IMM0_W = 4,
    parameter int IMM1_W = 5,
    parameter int IMM2_W = 6
) (
    input  logic [1:0]       opsel,
    input  logic [WIDTH-1:0] rb,
    input  logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] operand
);

    logic [WIDTH-1:0] imm0, imm1, imm2;
    logic             unused_ir;

    assign imm0 = {{(WIDTH-IMM0_W){ir[IMM0_W-1]}}, ir[IMM0_W-1:0]};
    assign imm1 = {{(WIDTH-IMM1_W){ir[IMM1_W-1]}}, ir[IMM1_W-1:0]};
    assign imm2 = {{(WIDTH-IMM2_W){ir[IMM2_W-1]}}, ir[IMM2_W-1:0]};

    // Upper instruction bits are opcode/register fields not consumed here.
    assign unused_ir = ^ir;

    always_comb begin
        operand = rb;
        case (opsel_t'(opsel))
            OP_IMM0: operand = imm0;
            OP_IMM1: operand = imm1;
            OP_IMM2: operand = imm2;
            default: operand = rb;
        endcase
    end

endmodule

// File: rtl/operand_shifter.sv
// Serial operand shifter: captures a selected operand and shifts it one bit
// per cycle in a single working register that also serves as the result.
module operand_shifter
    import lc3b_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int AMT_W  = 4,
    parameter int IMM0_W = 4,
    parameter int IMM1_W = 5,
    parameter int IMM2_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opsel,
    input  logic [WIDTH-1:0] rb,
    input  logic [WIDTH-1:0] ir,
    input  logic [1:0]       shmode,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state, state_n;
    shmode_t          mode, mode_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] step;

    operand_select #(
        .WIDTH  (WIDTH),
        .IMM0_W (IMM0_W),
        .IMM1_W (IMM1_W),
        .IMM2_W (IMM2_W)
    ) u_sel (
        .opsel   (opsel),
        .rb      (rb),
        .ir      (ir),
        .operand (operand)
    );

    // One-bit step of the working register in the captured mode.
    always_comb begin
        step = sreg;
        case (mode)
            SH_LSHF:  step = {sreg[WIDTH-2:0], 1'b0};
            SH_RSHFL: step = {1'b0, sreg[WIDTH-1:1]};
            SH_RSHFA: step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
            default:  step = sreg;
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode;
        cnt_n   = cnt;
        sreg_n  = sreg;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sreg_n = operand;
                    mode_n = shmode_t'(shmode);
                    if (shmode_t'(shmode) == SH_PASS || amount == '0) begin
                        cnt_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        cnt_n   = amount;
                        state_n = S_SHIFT;
                    end
                end else if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
            end
            S_SHIFT: begin
                sreg_n = step;
                cnt_n  = cnt - 1'b1;
                if (cnt == AMT_W'(1))
                    state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            mode  <= SH_PASS;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            mode  <= mode_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
        end
    end

    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);
    assign result = sreg;

endmodule
